// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary pointer helpers.
// Used by both the read-side controller and the write-side full logic.
package fifo_pkg;

  localparam int unsigned DSIZE   = 36;
  localparam int unsigned ASIZE   = 3;
  // Helpers work on a fixed wide vector; callers zero-extend and truncate to their pointer width.
  localparam int unsigned PTR_MAX = 16;

  // Binary to reflected Gray code.
  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray code to binary (prefix XOR from the MSB down).
  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = int'(PTR_MAX) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for Gray-coded pointers crossing clock domains.
module sync_ff #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage;

  // Plain shift chain, no logic between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the async FIFO: read pointer, synchronised write
// pointer, registered empty flag and a valid/ready output register.
// Optional build macro FIFO_RD_LEVEL_EN adds a registered fill-level output rlevel.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE       = fifo_pkg::DSIZE,
  parameter int unsigned ASIZE       = fifo_pkg::ASIZE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [ASIZE:0]   wptr_gray,
  output logic [ASIZE-1:0] raddr,
  input  logic [DSIZE-1:0] rdata_mem,
  output logic [ASIZE:0]   rptr_gray,
  output logic             rempty,
  output logic [DSIZE-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ASIZE:0]   rlevel
`endif
);

  localparam int unsigned PW = ASIZE + 1;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("fifo_rd_ctrl: SYNC_STAGES must be 2..4");
  end

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] rq_wptr;
  logic          pop;

  // Bring the write-domain Gray pointer into rclk.
  sync_ff #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .d     (wptr_gray),
    .q     (rq_wptr)
  );

  // Pop whenever a word is available and the output register is free or draining.
  always_comb begin
    pop       = !rempty && (!dout_valid || dout_ready);
    rbinnext  = rbin + PW'(pop);
    rgraynext = PW'(bin2gray(PTR_MAX'(rbinnext)));
  end

  assign raddr = rbin[ASIZE-1:0];

  // Pointer and empty flag; empty is computed from the next pointer so it rises on the last pop.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin      <= '0;
      rptr_gray <= '0;
      rempty    <= 1'b1;
    end else begin
      rbin      <= rbinnext;
      rptr_gray <= rgraynext;
      rempty    <= (rgraynext == rq_wptr);
    end
  end

  // Output register: load on pop, drop valid once the held word is accepted.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (pop) begin
      dout       <= rdata_mem;
      dout_valid <= 1'b1;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0] wbin_sync;

  assign wbin_sync = PW'(gray2bin(PTR_MAX'(rq_wptr)));

  // Words still in memory, as seen through the synchroniser; excludes the word in dout.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel <= '0;
    end else begin
      rlevel <= wbin_sync - rbinnext;
    end
  end
`endif

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller for the 36-bit x 8 async FIFO memory.
- Owns the read pointer and synchronises the write-domain Gray pointer into rclk.
- Generates the registered empty flag and drives the memory read address.
- Presents each popped word through a registered valid/ready output stage to the downstream data formatter.
- Lives entirely in the read clock domain and exports its Gray read pointer for the write-side full logic.

Parameters:
DSIZE, 36, data word width
ASIZE, 3, memory address width (depth = 2**ASIZE = 8)
SYNC_STAGES, 2, flops in the write-pointer synchroniser (legal: 2..4)

Ports:
rclk  input  1  read clock; all state on its rising edge
rrst_n  input  1  asynchronous active-low reset, release synchronised externally
wptr_gray  input  ASIZE+1  Gray write pointer from write domain (asynchronous to rclk)
raddr  output  ASIZE  read address to FIFO memory (combinational read)
rdata_mem  input  DSIZE  memory read data for raddr
rptr_gray  output  ASIZE+1  registered Gray read pointer, to write-side synchroniser
rempty  output  1  registered empty flag
dout  output  DSIZE  output data register
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  downstream accepts dout this cycle

Behaviour:
- Reset (rrst_n low, asynchronous): rbin=0, rptr_gray=0, all sync flops=0, rempty=1, dout=0, dout_valid=0. Reset mid-operation discards any word held in dout; no pop occurs in the reset-release cycle.
- Synchroniser: wptr_gray passes through SYNC_STAGES flops; the last stage is rq_wptr. No logic between stages.
- Binary pointer rbin[ASIZE:0]; raddr = rbin[ASIZE-1:0].
- pop = !rempty && (!dout_valid || dout_ready).
- rbinnext = rbin + pop, with natural wrap modulo 2**(ASIZE+1).
- rgraynext = (rbinnext>>1) ^ rbinnext.
- Per edge:
  - rbin <= rbinnext.
  - rptr_gray <= rgraynext.
  - rempty <= (rgraynext == rq_wptr).
- Output stage:
  - On pop: dout <= rdata_mem and dout_valid <= 1.
  - Else if dout_ready: dout_valid <= 0 and dout holds its value.
  - Pop while dout_ready is high gives back-to-back transfer, 1 word/cycle sustained.
- dout is stable while dout_valid=1 and dout_ready=0.
- Latency, from the first rclk edge that samples a new wptr_gray:
  - rempty falls after edge SYNC_STAGES+1.
  - dout_valid rises after edge SYNC_STAGES+2 (4 with defaults).
- Empty boundary: after the last word is popped, rempty rises on the same edge. No pop is ever issued while rempty=1. A stale synchronised pointer only delays the fall of rempty; it never causes it to fall early.
- Full boundary: ownership of the full flag is write-side. This block tolerates 8 words outstanding; pointer MSB difference distinguishes full from empty.
- Wrap: after 16 pops rbin returns to 0; the Gray sequence remains single-bit-change.
- No mode registers; no FSM beyond the pointer/valid state.

Optional Feature:
FIFO_RD_LEVEL_EN
- Defined:
  - Adds output rlevel [ASIZE:0] and a Gray-to-binary converter on rq_wptr.
  - rlevel <= wbin_sync - rbinnext (modulo 2**(ASIZE+1)), registered, range 0..8.
  - rlevel resets to 0.
  - It is pessimistic by the synchroniser delay and excludes the word held in dout.
- Undefined: no rlevel port and no converter logic.

Decomposition:
- Shared package fifo_pkg: DSIZE/ASIZE defaults plus bin2gray and gray2bin functions, shared with the write-side full block.
- One sub-module: sync_ff (parameterised width and stage count, async active-low reset), also reused by the write side.

Test Plan:
- Reset: hold rrst_n=0 with wptr_gray=4'b0011 toggling -> rempty=1, dout_valid=0, rptr_gray=0, raddr=0. Release rrst_n -> no pop until synchronisation completes.
- Single word: mem[0]=36'h123456789, step wptr_gray 0->1 -> rempty falls after edge 3, dout_valid rises after edge 4 with dout=36'h123456789, rptr_gray=4'b0001.
- Back-to-back: 8 words loaded, wptr_gray=4'b1100 (bin 8), dout_ready=1 constantly -> 8 consecutive valid cycles with words in order, then rempty=1 and dout_valid falls on the following edge.
- Backpressure: dout_ready=0 for 5 cycles with 3 words pending -> dout frozen on the first word, rbin advances only to 1; release -> words 2 and 3 follow on consecutive cycles.
- Wrap: stream 20 words through -> rbin wraps 15->0, rptr_gray sequence 1000->0000 changes one bit, data order intact.
- Mid-operation reset: pulse rrst_n low while dout_valid=1 -> dout_valid=0 and dout=0 immediately (asynchronous). With FIFO_RD_LEVEL_EN, rlevel=0 during reset and rlevel=5 settling 3 edges after wptr reaches bin 5 with 0 reads.
